// File: rtl/station_arbiter_pkg.sv
// station_arbiter_pkg: shared width default, station indices and FSM state type.
package station_arbiter_pkg;
  localparam int WIDTH_DEF = 4;
  localparam logic [1:0] LIB = 2'd0;
  localparam logic [1:0] FIRE = 2'd1;
  localparam logic [1:0] SCHOOL = 2'd2;
  localparam logic [1:0] RIB = 2'd3;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/station_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick of the first request after last_i, wrapping 3->0.
module rr_pick (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic       any_o,
  output logic [1:0] win_o
);
  // Scan farthest-to-nearest so the closest request after last_i overwrites the others.
  always_comb begin
    any_o = 1'b0;
    win_o = last_i;
    for (int k = 4; k >= 1; k--) begin
      if (req_i[last_i + 2'(k)]) begin
        any_o = 1'b1;
        win_o = last_i + 2'(k);
      end
    end
  end
endmodule

// File: rtl/station_arbiter.sv
// station_arbiter: round-robin merge of four station words into one valid/ready stream.
module station_arbiter
  import station_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             lib_req,
  input  logic             fire_req,
  input  logic             school_req,
  input  logic             rib_req,
  input  logic [WIDTH-1:0] lib_data,
  input  logic [WIDTH-1:0] fire_data,
  input  logic [WIDTH-1:0] school_data,
  input  logic [WIDTH-1:0] rib_data,
  output logic [3:0]       src_ack,
  output logic [WIDTH-1:0] Y,
  output logic [1:0]       sel,
  output logic             valid,
  input  logic             ready,
  output logic [7:0]       xfer_count
);
  state_t state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d, win_data;
  logic [1:0] sel_q, sel_d, last_q, last_d, win;
  logic [3:0] ack_q, ack_d, req_m;
  logic [7:0] xc_q, xc_d;
  logic any, grant, xfer;
  // A station acked this cycle may still hold its req; mask it to avoid a double grant.
  assign req_m = {rib_req, school_req, fire_req, lib_req} & ~ack_q;
  rr_pick u_pick (
    .req_i (req_m),
    .last_i(last_q),
    .any_o (any),
    .win_o (win)
  );
  assign win_data = (win == LIB) ? lib_data : (win == FIRE) ? fire_data :
                    (win == SCHOOL) ? school_data : rib_data;
  assign xfer  = (state_q == SEND) && ready;
  assign grant = enable && any && ((state_q == IDLE) || ready);
  always_comb begin
    state_d = grant ? SEND : xfer ? IDLE : state_q;
    y_d     = grant ? win_data : y_q;
    sel_d   = grant ? win : sel_q;
    last_d  = grant ? win : last_q;
    ack_d   = grant ? (4'b0001 << win) : 4'b0000;
    xc_d    = xfer ? xc_q + 8'd1 : xc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      sel_q   <= LIB;
      last_q  <= RIB;
      ack_q   <= '0;
      xc_q    <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      xc_q    <= xc_d;
    end
  end
  assign valid      = (state_q == SEND);
  assign Y          = y_q;
  assign sel        = sel_q;
  assign src_ack    = ack_q;
  assign xfer_count = xc_q;
endmodule

// File: tb/tb_station_arbiter.sv
// tb_station_arbiter: table-driven vectors through a scoreboard queue plus reset and wrap sequences.
module tb_station_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, ready = 1'b0;
  logic lib_req = 1'b0, fire_req = 1'b0, school_req = 1'b0, rib_req = 1'b0;
  logic [3:0] lib_data = 4'h1, fire_data = 4'hA, school_data = 4'h5, rib_data = 4'hC;
  logic [3:0] src_ack, Y;
  logic [1:0] sel;
  logic valid;
  logic [7:0] xfer_count;
  int checks = 0, errors = 0;

  typedef struct {
    logic en;
    logic [3:0] req;
    logic rdy;
    logic [18:0] exp;
  } vec_t;
  vec_t vecs[$];
  logic [18:0] sb[$];
  string sb_name[$];

  station_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .lib_req(lib_req), .fire_req(fire_req), .school_req(school_req), .rib_req(rib_req),
    .lib_data(lib_data), .fire_data(fire_data), .school_data(school_data), .rib_data(rib_data),
    .src_ack(src_ack), .Y(Y), .sel(sel), .valid(valid), .ready(ready), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] pk(logic v, logic [1:0] s, logic [3:0] y, logic [3:0] a, logic [7:0] c);
    return {v, s, y, a, c};
  endfunction

  task automatic add(logic en, logic [3:0] req, logic rdy, logic v, logic [1:0] s, logic [3:0] y,
                     logic [3:0] a, logic [7:0] c);
    vec_t t;
    t.en = en; t.req = req; t.rdy = rdy; t.exp = pk(v, s, y, a, c);
    vecs.push_back(t);
  endtask

  task automatic compare(string name);
    logic [18:0] e, got;
    string n;
    e = sb.pop_front();
    n = sb_name.pop_front();
    got = pk(valid, sel, Y, src_ack, xfer_count);
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s/%s got v=%b sel=%b Y=%h ack=%b xc=%0d expected v=%b sel=%b Y=%h ack=%b xc=%0d",
               name, n, got[18], got[17:16], got[15:12], got[11:8], got[7:0],
               e[18], e[17:16], e[15:12], e[11:8], e[7:0]);
    end
  endtask

  task automatic step(string name, logic en, logic [3:0] req, logic rdy, logic [18:0] exp);
    enable = en;
    {rib_req, school_req, fire_req, lib_req} = req;
    ready = rdy;
    sb.push_back(exp);
    sb_name.push_back(name);
    @(posedge clk);
    #1;
    compare(name);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    enable = 1'b0;
    {rib_req, school_req, fire_req, lib_req} = 4'b0000;
    ready = 1'b0;
    #2;
    sb.push_back(pk(0, 0, 0, 0, 0));
    sb_name.push_back("in_reset");
    compare("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Vectors from reset (last_grant=3): all-request rotation, single fire, stall, mask, enable gating.
    add(1, 4'b1111, 1, 1, 2'd0, 4'h1, 4'b0001, 0);
    add(1, 4'b1111, 1, 1, 2'd1, 4'hA, 4'b0010, 1);
    add(1, 4'b1111, 1, 1, 2'd2, 4'h5, 4'b0100, 2);
    add(1, 4'b1111, 1, 1, 2'd3, 4'hC, 4'b1000, 3);
    add(1, 4'b1111, 1, 1, 2'd0, 4'h1, 4'b0001, 4);
    add(1, 4'b0000, 1, 0, 2'd0, 4'h1, 4'b0000, 5);
    add(1, 4'b0010, 1, 1, 2'd1, 4'hA, 4'b0010, 5);
    add(1, 4'b0000, 1, 0, 2'd1, 4'hA, 4'b0000, 6);
    add(1, 4'b0100, 0, 1, 2'd2, 4'h5, 4'b0100, 6);
    add(1, 4'b0000, 0, 1, 2'd2, 4'h5, 4'b0000, 6);
    add(1, 4'b0000, 0, 1, 2'd2, 4'h5, 4'b0000, 6);
    add(1, 4'b0000, 0, 1, 2'd2, 4'h5, 4'b0000, 6);
    add(1, 4'b0000, 1, 0, 2'd2, 4'h5, 4'b0000, 7);
    add(1, 4'b0001, 1, 1, 2'd0, 4'h1, 4'b0001, 7);
    add(1, 4'b0001, 1, 0, 2'd0, 4'h1, 4'b0000, 8);
    add(1, 4'b0001, 1, 1, 2'd0, 4'h1, 4'b0001, 8);
    add(1, 4'b0000, 1, 0, 2'd0, 4'h1, 4'b0000, 9);
    add(1, 4'b1000, 0, 1, 2'd3, 4'hC, 4'b1000, 9);
    add(0, 4'b0011, 0, 1, 2'd3, 4'hC, 4'b0000, 9);
    add(0, 4'b0011, 1, 0, 2'd3, 4'hC, 4'b0000, 10);
    add(0, 4'b0011, 1, 0, 2'd3, 4'hC, 4'b0000, 10);
    add(1, 4'b0011, 1, 1, 2'd0, 4'h1, 4'b0001, 10);
    add(1, 4'b0010, 1, 1, 2'd1, 4'hA, 4'b0010, 11);
    add(1, 4'b0000, 1, 0, 2'd1, 4'hA, 4'b0000, 12);

    do_reset();
    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].en, vecs[i].req, vecs[i].rdy, vecs[i].exp);

    // First transfer after reset: lone fire request.
    do_reset();
    step("fire_grant", 1, 4'b0010, 1, pk(1, 2'd1, 4'hA, 4'b0010, 0));
    step("fire_done", 1, 4'b0000, 1, pk(0, 2'd1, 4'hA, 4'b0000, 1));

    // Reset mid-SEND discards the held word; lib wins first afterwards.
    step("pre_rst_grant", 1, 4'b0100, 0, pk(1, 2'd2, 4'h5, 4'b0100, 1));
    step("pre_rst_hold", 1, 4'b0000, 0, pk(1, 2'd2, 4'h5, 4'b0000, 1));
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(pk(0, 0, 0, 0, 0));
    sb_name.push_back("async");
    compare("mid_send_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_lib", 1, 4'b1111, 1, pk(1, 2'd0, 4'h1, 4'b0001, 0));

    // Counter wrap: continuous traffic, 255 transfers then one more.
    for (int i = 1; i <= 254; i++) begin
      enable = 1'b1;
      {rib_req, school_req, fire_req, lib_req} = 4'b1111;
      ready = 1'b1;
      @(posedge clk);
    end
    #1;
    checks++;
    if (xfer_count !== 8'd254) begin
      errors++;
      $display("FAIL count_254 got %0d expected 254", xfer_count);
    end
    @(posedge clk);
    #1;
    checks++;
    if (xfer_count !== 8'd255) begin
      errors++;
      $display("FAIL count_255 got %0d expected 255", xfer_count);
    end
    @(posedge clk);
    #1;
    checks++;
    if (xfer_count !== 8'd0 || valid !== 1'b1) begin
      errors++;
      $display("FAIL count_wrap got xc=%0d v=%b expected xc=0 v=1", xfer_count, valid);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/station_arbiter.md
STATION_ARBITER -- requirements
Module: station_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width per station word.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port enable  input  1  high permits new grants.
REQ-005 SHALL have ports lib_req, fire_req, school_req, rib_req  input  1 each  station request, index 0..3 in that order (sel encoding 00/01/10/11).
REQ-006 SHALL have ports lib_data, fire_data, school_data, rib_data  input  WIDTH each  station word, valid while the matching req is high.
REQ-007 SHALL have port src_ack  output  4  one-cycle grant pulse, bit n = station n.
REQ-008 SHALL have port Y  output  WIDTH  merged data word.
REQ-009 SHALL have port sel  output  2  index of the station that sourced Y.
REQ-010 SHALL have port valid  output  1  Y/sel hold a word.
REQ-011 SHALL have port ready  input  1  downstream accepts the word when valid&&ready.
REQ-012 SHALL have port xfer_count  output  8  count of completed downstream transfers.

Function
REQ-013 SHALL implement FSM states IDLE (valid=0) and SEND (valid=1).
REQ-014 IDLE: if enable and any unmasked req at edge N, SHALL register winner's data into Y, index into sel, set valid=1, pulse src_ack[winner] for cycle N+1, go SEND; else stay IDLE.
REQ-015 Winner SHALL be chosen round-robin: first requesting index after last_grant, wrapping 3->0.
REQ-016 A station whose src_ack bit is high in the current cycle SHALL be masked from arbitration that cycle (no double grant of a held request).
REQ-017 SEND with ready=0: Y, sel, valid SHALL hold stable; no grant, src_ack=0.
REQ-018 SEND with ready=1: if enable and an unmasked req exists, SHALL load the next winner at the same edge (back-to-back, 1 word/cycle); else valid->0, go IDLE.
REQ-019 ready SHALL be ignored while valid=0.
REQ-020 enable low SHALL block new grants only; a word already in SEND SHALL complete normally.
REQ-021 xfer_count SHALL increment on every edge with valid&&ready, wrapping 255->0.
REQ-022 last_grant SHALL update only on a grant.
REQ-023 Request-to-valid latency SHALL be exactly 1 cycle; src_ack SHALL coincide with the first valid cycle of that word.

Reset
REQ-024 rst_n low SHALL asynchronously force: state=IDLE, valid=0, Y=0, sel=0, src_ack=0, xfer_count=0, last_grant=3 (station 0 highest priority first).
REQ-025 Reset asserted mid-SEND SHALL discard the held word without ack or count; first grant after release SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-026 Shared package SHALL hold WIDTH default, station index constants (LIB=0, FIRE=1, SCHOOL=2, RIB=3) and the FSM state typedef.
REQ-027 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: 4-bit masked req, 2-bit last_grant; outputs: any, 2-bit winner).

Verification
REQ-028 Reset release, ready=1, only fire_req with fire_data=0xA -> next cycle valid=1, Y=0xA, sel=01, src_ack=0010; xfer_count=1 after that edge.
REQ-029 All four req high continuously, ready=1, enable=1 -> sel sequence 00,01,10,11,00 on consecutive cycles, each src_ack a single pulse.
REQ-030 school_req with data 0x5, ready=0 for 3 cycles then 1 -> Y=0x5, sel=10 held 4 cycles, one src_ack pulse, xfer_count +1.
REQ-031 enable dropped while valid=1, ready=0, then ready=1 with requests pending -> held word completes, valid->0, no further src_ack until enable=1.
REQ-032 rst_n pulsed low mid-SEND -> valid, Y, sel, src_ack, xfer_count immediately 0; after release lib wins first.
REQ-033 xfer_count preloaded by 255 transfers, one more -> xfer_count=0.
